count_sched_ctrl: RTL and testbench

COUNT_SCHED_CTRL -- requirements
Module: count_sched_ctrl

---
 rtl/count_sched_pkg.sv | 13 +
 rtl/count_sched_core.sv | 23 ++
 rtl/count_sched_ctrl.sv | 121 ++++++++++++
 tb/tb_count_sched_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types for the count scheduler: controller state encoding and run-mode constants.
package count_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_sched_core.sv
// Loadable, clearable, enabled up-counter; clear beats load, load beats enable.
module count_sched_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/count_sched_ctrl.sv
// Count scheduler controller: IDLE/RUN/DONE FSM driving a terminal-count counter.
// Optional tick prescaler is enabled with COUNT_SCHED_PRESCALE_EN.
module count_sched_ctrl
   import count_sched_pkg::*;
#(
   parameter int WIDTH    = 4
`ifdef COUNT_SCHED_PRESCALE_EN
  ,parameter int PRESCALE = 4
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic             cfg_periodic,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] period_q;
   logic             mode_q;
   logic             tc_d, done_d;
   logic             cnt_clr, cnt_load, cnt_en;
   logic             tick;
   logic             cfg_fire;

   assign cfg_ready = (state_q != RUN);
   assign busy      = (state_q == RUN);
   assign cfg_fire  = cfg_valid && cfg_ready;

`ifdef COUNT_SCHED_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q;
   logic          pre_clr;

   // Prescaler restarts whenever the count itself restarts (start, stop, reload).
   assign pre_clr = cnt_clr || cnt_load;
   assign tick    = (state_q == RUN) && (pre_q == PW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst || pre_clr)
         pre_q <= '0;
      else if (state_q == RUN)
         pre_q <= (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + 1'b1;
   end
`else
   assign tick = (state_q == RUN);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         period_q <= '0;
         mode_q   <= MODE_ONESHOT;
         tc       <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q <= state_d;
         tc      <= tc_d;
         done    <= done_d;
         if (cfg_fire) begin
            period_q <= cfg_period;
            mode_q   <= cfg_periodic;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      tc_d     = 1'b0;
      done_d   = done;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // A simultaneous start/stop cancels out and leaves the state alone.
            if (start && !stop) begin
               state_d = RUN;
               cnt_clr = 1'b1;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               cnt_clr = 1'b1;
            end else if (tick) begin
               if (count == period_q) begin
                  tc_d = 1'b1;
                  if (mode_q == MODE_PERIODIC)
                     cnt_load = 1'b1;
                  else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end else
                  cnt_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   count_sched_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val ({WIDTH{1'b0}}),
      .en       (cnt_en),
      .count    (count)
   );

endmodule

// File: tb/tb_count_sched_ctrl.sv
// Bench for count_sched_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_count_sched_ctrl;

   localparam int WIDTH = 4;
`ifdef COUNT_SCHED_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_period = '0;
   logic             cfg_periodic = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             busy;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             done;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   count_sched_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_period   (cfg_period),
      .cfg_periodic (cfg_periodic),
      .start        (start),
      .stop         (stop),
      .busy         (busy),
      .count        (count),
      .tc           (tc),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: running flag, count, period, mode, prescale phase.
   bit m_run, m_tc, m_done, m_mode, m_tick;
   int m_cnt, m_per, m_pre;

   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; m_tc = 0; m_done = 0; m_mode = 0;
         m_cnt = 0; m_per = 0; m_pre = 0;
      end else begin
         m_tc   = 0;
         m_tick = m_run && (m_pre == PS - 1);
         if (!m_run) begin
            if (cfg_valid) begin
               m_per  = int'(cfg_period);
               m_mode = cfg_periodic;
            end
            if (start && !stop) begin
               m_run = 1; m_cnt = 0; m_done = 0; m_pre = 0;
            end
         end else if (stop) begin
            m_run = 0; m_cnt = 0; m_pre = 0;
         end else begin
            m_pre = (m_pre + 1) % PS;
            if (m_tick) begin
               if (m_cnt == m_per) begin
                  m_tc = 1;
                  if (m_mode) begin
                     m_cnt = 0; m_pre = 0;
                  end else begin
                     m_run = 0; m_done = 1;
                  end
               end else
                  m_cnt = m_cnt + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("mdl_count", int'(count), m_cnt);
         chk("mdl_tc", int'(tc), int'(m_tc));
         chk("mdl_done", int'(done), int'(m_done));
         chk("mdl_busy", int'(busy), int'(m_run));
         chk("mdl_cfg_ready", int'(cfg_ready), int'(!m_run));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_start(input int per, input bit periodic);
      cfg_valid = 1; cfg_period = WIDTH'(per); cfg_periodic = periodic; start = 1;
      step();
      cfg_valid = 0; start = 0;
   endtask

   initial begin
      step(2);
      rst = 0;
      armed = 1;
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_tc", int'(tc), 0);

`ifdef COUNT_SCHED_PRESCALE_EN
      // period 1, periodic: count advances every 4 clocks, tc every 8
      cfg_start(1, 1);
      chk("ps_c0", int'(count), 0);
      for (int c = 1; c <= 16; c++) begin
         step();
         chk("ps_count", int'(count), (c / 4) % 2);
         chk("ps_tc", int'(tc), (c % 8 == 0) ? 1 : 0);
      end
      stop = 1; step(); stop = 0;
      chk("ps_stop_busy", int'(busy), 0);
`else
      // one-shot, period 3
      cfg_start(3, 0);
      chk("os_c0", int'(count), 0);
      chk("os_busy", int'(busy), 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("os_count", int'(count), k);
         chk("os_tc_low", int'(tc), 0);
      end
      step();
      chk("os_tc", int'(tc), 1);
      chk("os_done", int'(done), 1);
      chk("os_hold", int'(count), 3);
      chk("os_busy_end", int'(busy), 0);
      step();
      chk("os_tc_pulse", int'(tc), 0);
      chk("os_hold2", int'(count), 3);
      chk("os_sticky", int'(done), 1);

      // periodic, period 2, restarted from DONE
      cfg_start(2, 1);
      chk("per_done_clr", int'(done), 0);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("per_count", int'(count), k % 3);
         chk("per_tc", int'(tc), (k % 3 == 0) ? 1 : 0);
      end
      // count==period now; stop must win
      chk("stop_at_tc_pre", int'(count), 2);
      stop = 1; step(); stop = 0;
      chk("stop_tc", int'(tc), 0);
      chk("stop_busy", int'(busy), 0);
      chk("stop_count", int'(count), 0);

      // cfg offered while running is ignored
      cfg_start(4, 0);
      cfg_valid = 1; cfg_period = 4'd9; cfg_periodic = 1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("ign_count", int'(count), k);
      end
      cfg_valid = 0;
      step();
      chk("ign_done", int'(done), 1);
      chk("ign_hold", int'(count), 4);
      chk("ign_tc", int'(tc), 1);

      // reset mid-run at count 5
      cfg_start(7, 0);
      step(5);
      chk("mid_pre", int'(count), 5);
      rst = 1; step(); rst = 0;
      chk("mid_count", int'(count), 0);
      chk("mid_busy", int'(busy), 0);
      chk("mid_ready", int'(cfg_ready), 1);

      // reset left period 0 one-shot: done after first tick
      start = 1; step(); start = 0;
      chk("p0_c0", int'(count), 0);
      step();
      chk("p0_done", int'(done), 1);
      chk("p0_tc", int'(tc), 1);
      chk("p0_count", int'(count), 0);

      // period 0 periodic: tc every tick
      cfg_start(0, 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("p0p_tc", int'(tc), 1);
         chk("p0p_count", int'(count), 0);
      end
      stop = 1; step(); stop = 0;

      // simultaneous start/stop in IDLE does nothing
      start = 1; stop = 1; step(); start = 0; stop = 0;
      chk("ss_busy", int'(busy), 0);

      // start held during RUN is ignored
      cfg_valid = 1; cfg_period = 4'd5; cfg_periodic = 1; start = 1;
      step();
      cfg_valid = 0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("hold_start", int'(count), k);
      end
      start = 0;
      stop = 1; step(); stop = 0;
`endif
      step(2);
      armed = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
